// File: rtl/mem_bus_if_pkg.sv
// ============================================================================
// mem_bus_if_pkg : shared encodings for the memory-stage bus interface
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef MEM_BUS_IF_PAGE_FIELD
`define MEM_BUS_IF_PAGE_FIELD(aw) ((aw)-1) -: 3
`endif

package mem_bus_if_pkg;

    localparam int         WORD_ADDR_W_DEF = 30;
    localparam int         WORD_DATA_W_DEF = 32;
    localparam logic [2:0] SPM_PAGE_DEF    = 3'b011;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_bus_if_if.sv
// ============================================================================
// mem_bus_if_if : upstream, SPM and system-bus signals of the bus interface
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_bus_if_if
    import mem_bus_if_pkg::*;
#(
    parameter int WORD_ADDR_W = WORD_ADDR_W_DEF,
    parameter int WORD_DATA_W = WORD_DATA_W_DEF
);
    logic                   stall;
    logic                   flush;
    logic                   busy;
    logic [WORD_ADDR_W-1:0] addr;
    logic                   as_;
    logic                   rw;
    logic [WORD_DATA_W-1:0] wr_data;
    logic [WORD_DATA_W-1:0] rd_data;

    logic [WORD_DATA_W-1:0] spm_rd_data;
    logic [WORD_ADDR_W-1:0] spm_addr;
    logic                   spm_as_;
    logic                   spm_rw;
    logic [WORD_DATA_W-1:0] spm_wr_data;

    logic [WORD_DATA_W-1:0] bus_rd_data;
    logic                   bus_rdy_;
    logic                   bus_grnt_;
    logic                   bus_req_;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic                   bus_as_;
    logic                   bus_rw;
    logic [WORD_DATA_W-1:0] bus_wr_data;

    modport slave (
        input  stall, flush, addr, as_, rw, wr_data,
        input  spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        output busy, rd_data, spm_addr, spm_as_, spm_rw, spm_wr_data,
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );

    modport master (
        output stall, flush, addr, as_, rw, wr_data,
        output spm_rd_data, bus_rd_data, bus_rdy_, bus_grnt_,
        input  busy, rd_data, spm_addr, spm_as_, spm_rw, spm_wr_data,
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_if.sv
// ============================================================================
// mem_bus_if : routes memory-stage accesses to the SPM or the shared system bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int         WORD_ADDR_W = WORD_ADDR_W_DEF,
    parameter int         WORD_DATA_W = WORD_DATA_W_DEF,
    parameter logic [2:0] SPM_PAGE    = SPM_PAGE_DEF
) (
    input  wire logic      clk,
    input  wire logic      reset_,
    mem_bus_if_if.slave    bif
);

    bus_if_state_e          r_state;
    logic                   r_bus_req_;
    logic [WORD_ADDR_W-1:0] r_bus_addr;
    logic                   r_bus_as_;
    logic                   r_bus_rw;
    logic [WORD_DATA_W-1:0] r_bus_wr_data;
    logic [WORD_DATA_W-1:0] r_rd_buf;

    logic                   w_spm_hit;
    logic                   w_busy;
    logic [WORD_DATA_W-1:0] w_rd_data;
    logic                   w_spm_as_;

    assign w_spm_hit = (bif.addr[`MEM_BUS_IF_PAGE_FIELD(WORD_ADDR_W)] == SPM_PAGE);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state       <= BUS_IF_STATE_IDLE;
            r_bus_req_    <= 1'b1;
            r_bus_addr    <= '0;
            r_bus_as_     <= 1'b1;
            r_bus_rw      <= READ;
            r_bus_wr_data <= '0;
            r_rd_buf      <= '0;
        end else begin
            case (r_state)
                BUS_IF_STATE_IDLE: begin
                    if (!bif.flush && !bif.as_ && !w_spm_hit) begin
                        r_state       <= BUS_IF_STATE_REQ;
                        r_bus_req_    <= 1'b0;
                        r_bus_addr    <= bif.addr;
                        r_bus_rw      <= bif.rw;
                        r_bus_wr_data <= bif.wr_data;
                    end
                end
                BUS_IF_STATE_REQ: begin
                    if (!bif.bus_grnt_) begin
                        r_state   <= BUS_IF_STATE_ACCESS;
                        r_bus_as_ <= 1'b0;
                    end
                end
                BUS_IF_STATE_ACCESS: begin
                    // Strobe is a single-cycle pulse; completion depends on ready only
                    r_bus_as_ <= 1'b1;
                    if (!bif.bus_rdy_) begin
                        r_bus_req_    <= 1'b1;
                        r_bus_addr    <= '0;
                        r_bus_rw      <= READ;
                        r_bus_wr_data <= '0;
                        if (r_bus_rw == READ) begin
                            r_rd_buf <= bif.bus_rd_data;
                        end
                        r_state <= bif.stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                    end
                end
                BUS_IF_STATE_STALL: begin
                    if (!bif.stall) begin
                        r_state <= BUS_IF_STATE_IDLE;
                    end
                end
                default: r_state <= BUS_IF_STATE_IDLE;
            endcase
        end
    end

    // No strobe and no stall request while reset is held
    always_comb begin
        w_busy    = 1'b0;
        w_rd_data = '0;
        w_spm_as_ = 1'b1;
        if (reset_) begin
            case (r_state)
                BUS_IF_STATE_IDLE: begin
                    if (!bif.flush && !bif.as_) begin
                        if (w_spm_hit) begin
                            w_spm_as_ = 1'b0;
                            w_rd_data = bif.spm_rd_data;
                        end else begin
                            w_busy = 1'b1;
                        end
                    end
                end
                BUS_IF_STATE_REQ: w_busy = 1'b1;
                BUS_IF_STATE_ACCESS: begin
                    if (bif.bus_rdy_) begin
                        w_busy = 1'b1;
                    end else if (r_bus_rw == READ) begin
                        w_rd_data = bif.bus_rd_data;
                    end
                end
                BUS_IF_STATE_STALL: w_rd_data = r_rd_buf;
                default: w_busy = 1'b0;
            endcase
        end
    end

    assign bif.busy        = w_busy;
    assign bif.rd_data     = w_rd_data;
    assign bif.spm_as_     = w_spm_as_;
    assign bif.spm_addr    = bif.addr;
    assign bif.spm_rw      = bif.rw;
    assign bif.spm_wr_data = bif.wr_data;
    assign bif.bus_req_    = r_bus_req_;
    assign bif.bus_addr    = r_bus_addr;
    assign bif.bus_as_     = r_bus_as_;
    assign bif.bus_rw      = r_bus_rw;
    assign bif.bus_wr_data = r_bus_wr_data;

endmodule

`default_nettype wire
